i_ddr_deser: RTL and testbench



---
 rtl/ddr_pkg.sv | 16 +
 rtl/i_ddr_capture.sv | 60 ++++++
 rtl/i_ddr_deser.sv | 102 ++++++++++
 tb/tb_i_ddr_deser.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared constants and elaboration helpers for the input DDR deserializer.
// Both the capture front end and the word gearbox import this package.
package ddr_pkg;

    localparam int PAIR_W = 2;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    // Gearbox consumes whole pairs, so the word must hold an even bit count.
    function automatic bit width_ok(input int width);
        return (width >= 4) && (width <= 16) && ((width % 2) == 0);
    endfunction

endpackage

// File: rtl/i_ddr_capture.sv
// Dual-edge front end: holds the falling-edge bit and re-forms {bit1, bit0}
// pairs on the rising edge of C.
module i_ddr_capture
    import ddr_pkg::*;
(
    input  logic              C,
    input  logic              R,
    input  logic              E,
    input  logic              D,
    output logic [PAIR_W-1:0] pair_o,
    output logic              pair_vld_o
);

    logic              d_fall_q;
    logic              d_fall_d;
    logic [PAIR_W-1:0] pair_q;
    logic [PAIR_W-1:0] pair_d;
    logic              pair_vld_q;
    logic              pair_vld_d;

    // Next-state for both capture stages; E low freezes everything.
    always_comb begin
        d_fall_d   = d_fall_q;
        pair_d     = pair_q;
        pair_vld_d = pair_vld_q;
        if (E) begin
            d_fall_d   = D;
            pair_d     = {D, d_fall_q};
            pair_vld_d = 1'b1;
        end else begin
            d_fall_d   = d_fall_q;
            pair_d     = pair_q;
            pair_vld_d = pair_vld_q;
        end
    end

    // Bit0 is launched while C is high, so it is taken on the falling edge.
    always_ff @(negedge C) begin
        if (!R) begin
            d_fall_q <= 1'b0;
        end else begin
            d_fall_q <= d_fall_d;
        end
    end

    // Rising edge completes the pair with bit1.
    always_ff @(posedge C) begin
        if (!R) begin
            pair_q     <= {PAIR_W{1'b0}};
            pair_vld_q <= 1'b0;
        end else begin
            pair_q     <= pair_d;
            pair_vld_q <= pair_vld_d;
        end
    end

    assign pair_o     = pair_q;
    assign pair_vld_o = pair_vld_q;

endmodule

// File: rtl/i_ddr_deser.sv
// Input DDR deserializer: captured pairs are packed LSB-first into WIDTH-bit
// words, with BITSLIP dropping one bit to move the word boundary.
module i_ddr_deser
    import ddr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             C,
    input  logic             R,
    input  logic             E,
    input  logic             D,
    input  logic             BITSLIP,
    output logic [WIDTH-1:0] Q,
    output logic             Q_VALID
);

    localparam int              CNT_W   = cnt_width(WIDTH);
    localparam logic [CNT_W:0]  WIDTH_C = (CNT_W + 1)'(WIDTH);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("i_ddr_deser: WIDTH must be even and within 4..16");
    end

    logic [PAIR_W-1:0] pair_s;
    logic              pair_vld_s;

    i_ddr_capture u_capture (
        .C          (C),
        .R          (R),
        .E          (E),
        .D          (D),
        .pair_o     (pair_s),
        .pair_vld_o (pair_vld_s)
    );

    logic [WIDTH-2:0] acc_q;
    logic [WIDTH-2:0] acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             q_valid_q;
    logic             q_valid_d;

    logic [WIDTH:0]   new_ext_s;
    logic [WIDTH:0]   merged_s;
    logic [CNT_W:0]   n_s;
    logic [CNT_W:0]   sum_s;

    // Bits contributed this cycle, positioned at the fill level of acc.
    always_comb begin
        if (BITSLIP) begin
            new_ext_s = {{WIDTH{1'b0}}, pair_s[1]};
            n_s       = (CNT_W + 1)'(1);
        end else begin
            new_ext_s = {{(WIDTH - 1){1'b0}}, pair_s};
            n_s       = (CNT_W + 1)'(2);
        end
        merged_s = {2'b00, acc_q} | (new_ext_s << cnt_q);
        sum_s    = {1'b0, cnt_q} + n_s;
    end

    // Gearbox: accumulate, or emit a word and carry the spare bit over.
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        q_valid_d = 1'b0;
        if (E && pair_vld_s) begin
            if (sum_s >= WIDTH_C) begin
                q_d       = merged_s[WIDTH-1:0];
                q_valid_d = 1'b1;
                acc_d     = {{(WIDTH - 2){1'b0}}, merged_s[WIDTH]};
                cnt_d     = CNT_W'(sum_s - WIDTH_C);
            end else begin
                acc_d     = merged_s[WIDTH-2:0];
                cnt_d     = sum_s[CNT_W-1:0];
            end
        end else begin
            q_valid_d = 1'b0;
        end
    end

    // Gearbox state and output registers.
    always_ff @(posedge C) begin
        if (!R) begin
            acc_q     <= {(WIDTH - 1){1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            q_q       <= {WIDTH{1'b0}};
            q_valid_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
        end
    end

    assign Q       = q_q;
    assign Q_VALID = q_valid_q;

endmodule

// File: tb/tb_i_ddr_deser.sv
// Self-checking bench for i_ddr_deser (WIDTH=8): directed table, multi-cycle
// corner sequences, and random traffic against a bit-queue reference model.
module tb_i_ddr_deser;

    localparam int WIDTH = 8;

    logic             C = 1'b0;
    logic             R = 1'b0;
    logic             E = 1'b0;
    logic             D = 1'b0;
    logic             BITSLIP = 1'b0;
    logic [WIDTH-1:0] Q;
    logic             Q_VALID;

    i_ddr_deser #(.WIDTH(WIDTH)) dut (
        .C       (C),
        .R       (R),
        .E       (E),
        .D       (D),
        .BITSLIP (BITSLIP),
        .Q       (Q),
        .Q_VALID (Q_VALID)
    );

    always #5 C = ~C;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: received bits in arrival order, popped 8 at a time.
    bit               mq[$];
    logic [WIDTH-1:0] m_q    = '0;
    logic             m_qv   = 1'b0;
    logic [1:0]       m_pair = 2'b00;
    bit               m_pvld = 1'b0;

    logic [WIDTH-1:0] got_w[$];
    int               got_t[$];

    typedef struct {
        bit               r;
        bit               e;
        bit               s;
        bit               b0;
        bit               b1;
        logic [WIDTH-1:0] q;
        bit               qv;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mkv(bit r, bit e, bit s, bit b0, bit b1,
                                 logic [WIDTH-1:0] q, bit qv);
        vec_t v;
        v.r = r; v.e = e; v.s = s; v.b0 = b0; v.b1 = b1; v.q = q; v.qv = qv;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(bit r, bit e, bit s, bit b0, bit b1);
        if (!r) begin
            mq.delete();
            m_q    = '0;
            m_qv   = 1'b0;
            m_pair = 2'b00;
            m_pvld = 1'b0;
        end else if (e) begin
            m_qv = 1'b0;
            if (m_pvld) begin
                if (!s) mq.push_back(m_pair[0]);
                mq.push_back(m_pair[1]);
                if (mq.size() >= WIDTH) begin
                    for (int i = 0; i < WIDTH; i++) m_q[i] = mq.pop_front();
                    m_qv = 1'b1;
                end
            end
            m_pair = {b1, b0};
            m_pvld = 1'b1;
        end else begin
            m_qv = 1'b0;
        end
    endtask

    // One C period: bit0 driven while C high, bit1 while C low.
    task automatic cycle(bit r, bit e, bit s, bit b0, bit b1);
        R = r; E = e; BITSLIP = s; D = b0;
        @(negedge C);
        #1 D = b1;
        @(posedge C);
        #1;
        cyc++;
        model_step(r, e, s, b0, b1);
        check("model_q", 32'(Q), 32'(m_q));
        check("model_qv", 32'(Q_VALID), 32'(m_qv));
        if (Q_VALID === 1'b1) begin
            got_w.push_back(Q);
            got_t.push_back(cyc);
        end
    endtask

    task automatic send_word(logic [WIDTH-1:0] w);
        for (int i = 0; i < WIDTH / 2; i++) cycle(1'b1, 1'b1, 1'b0, w[2*i], w[2*i+1]);
    endtask

    task automatic clear_log();
        got_w.delete();
        got_t.delete();
    endtask

    int base;
    int nstrobe;

    initial begin
        // reset, A5 as pairs 01,01,10,10, then 3 pairs, reset, A5 again
        tbl[0]  = mkv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        tbl[1]  = mkv(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        tbl[2]  = mkv(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        tbl[3]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        tbl[4]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        tbl[5]  = mkv(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1);
        tbl[6]  = mkv(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0);
        tbl[7]  = mkv(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0);
        tbl[8]  = mkv(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
        tbl[9]  = mkv(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        tbl[10] = mkv(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        tbl[11] = mkv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        tbl[12] = mkv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        tbl[13] = mkv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1);

        @(posedge C);
        #1;
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].r, tbl[i].e, tbl[i].s, tbl[i].b0, tbl[i].b1);
            check($sformatf("tbl%0d_q", i), 32'(Q), 32'(tbl[i].q));
            check($sformatf("tbl%0d_qv", i), 32'(Q_VALID), 32'(tbl[i].qv));
        end

        // back-to-back words
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        clear_log();
        send_word(8'h3C);
        send_word(8'hFF);
        send_word(8'h00);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("b2b_count", 32'(got_w.size()), 32'd3);
        if (got_w.size() == 3) begin
            check("b2b_w0", 32'(got_w[0]), 32'h3C);
            check("b2b_w1", 32'(got_w[1]), 32'hFF);
            check("b2b_w2", 32'(got_w[2]), 32'h00);
            check("b2b_gap0", 32'(got_t[1] - got_t[0]), 32'd4);
            check("b2b_gap1", 32'(got_t[2] - got_t[1]), 32'd4);
        end

        // constant pair 10 with a slip on the first valid pair
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        base = cyc;
        clear_log();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("slip_count", 32'(got_w.size()), 32'd3);
        if (got_w.size() >= 2) begin
            check("slip_first_t", 32'(got_t[0] - base), 32'd6);
            check("slip_w0", 32'(got_w[0]), 32'h55);
            check("slip_w1", 32'(got_w[1]), 32'h55);
            check("slip_gap", 32'(got_t[1] - got_t[0]), 32'd4);
        end

        // same stream without the slip
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        clear_log();
        for (int i = 0; i < 13; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("noslip_count", 32'(got_w.size()), 32'd3);
        if (got_w.size() >= 1) check("noslip_w0", 32'(got_w[0]), 32'hAA);

        // enable hold mid-word, slip pulsed while disabled
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        clear_log();
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("hold_no_strobe", 32'(got_w.size()), 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("hold_count", 32'(got_w.size()), 32'd1);
        if (got_w.size() == 1) begin
            check("hold_w", 32'(got_w[0]), 32'hA5);
            check("hold_t", 32'(got_t[0]), 32'(cyc));
        end

        // BITSLIP held for two enabled cycles
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        base = cyc;
        clear_log();
        for (int i = 1; i <= 17; i++)
            cycle(1'b1, 1'b1, (i == 6 || i == 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("slip2_count", 32'(got_w.size()), 32'd3);
        if (got_w.size() == 3) begin
            check("slip2_first_t", 32'(got_t[0] - base), 32'd5);
            check("slip2_gap0", 32'(got_t[1] - got_t[0]), 32'd5);
            check("slip2_gap1", 32'(got_t[2] - got_t[1]), 32'd4);
        end

        // random traffic against the model
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        clear_log();
        for (int i = 0; i < 600; i++)
            cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        nstrobe = got_w.size();
        check("rnd_strobes_seen", 32'(nstrobe > 20), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
